// File: rtl/tempo_divider.sv
// rtl/tempo_divider.sv - debounced up/down tempo level selector with beat strobe generator
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   reset         synchronous active-high reset
//   key_up        raw pushbutton, active-high, requests a faster tempo
//   key_down      raw pushbutton, active-high, requests a slower tempo
//   enable        beat counter runs while high, holds while low
//   sel_valid     (TEMPO_SEL_EN only) load sel_level as the new level
//   sel_level     (TEMPO_SEL_EN only) requested level, clamped to LEVELS-1
//   level         current tempo level
//   period        current beat period in cycles (BASE_PERIOD >> level)
//   beat          one-cycle strobe, once per period
//   level_changed one-cycle strobe, coincident with a level update
//
// Optional feature macro: TEMPO_SEL_EN (direct level select port).

module tempo_divider #(
    parameter int CNT_W           = 28,
    parameter int LEVELS          = 4,
    parameter int LEVEL_W         = 2,
    parameter int BASE_PERIOD     = 40000000,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int DB_W            = 18,
    parameter int WRAP            = 1,
    parameter int RESET_LEVEL     = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_up,
    input  logic               key_down,
    input  logic               enable,
`ifdef TEMPO_SEL_EN
    input  logic               sel_valid,
    input  logic [LEVEL_W-1:0] sel_level,
`endif
    output logic [LEVEL_W-1:0] level,
    output logic [CNT_W-1:0]   period,
    output logic               beat,
    output logic               level_changed
);

    localparam logic [CNT_W-1:0]   BASE_P    = CNT_W'(BASE_PERIOD);
    localparam logic [LEVEL_W-1:0] LVL_MAX   = LEVEL_W'(LEVELS - 1);
    localparam logic [LEVEL_W-1:0] LVL_RESET = LEVEL_W'(RESET_LEVEL);
    localparam logic [DB_W-1:0]    DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    // Bit 0 carries the up key, bit 1 the down key.
    logic [1:0]         key_raw;
    logic [1:0]         s1_q;
    logic [1:0]         s2_q;
    logic [1:0]         db_q;
    logic [1:0]         db_prev_q;
    logic [1:0]         press;
    logic [DB_W-1:0]    db_cnt_q [2];

    logic [LEVEL_W-1:0] level_q;
    logic [LEVEL_W-1:0] level_d;
    logic [LEVEL_W-1:0] step_lvl;
    logic               level_changed_q;
    logic               level_changed_d;
    logic               restart;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic               beat_q;
    logic               beat_d;
`ifdef TEMPO_SEL_EN
    logic [LEVEL_W-1:0] sel_clamped;
`endif

    assign key_raw = {key_down, key_up};

    // Synchroniser and debouncer. The counter only runs while the synchronised
    // input disagrees with the accepted state, so any glitch shorter than
    // DEBOUNCE_CYCLES clears it before it can commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            db_q      <= '0;
            db_prev_q <= '0;
            for (int k = 0; k < 2; k++) begin
                db_cnt_q[k] <= '0;
            end
        end else begin
            s1_q      <= key_raw;
            s2_q      <= s1_q;
            db_prev_q <= db_q;
            for (int k = 0; k < 2; k++) begin
                if (s2_q[k] == db_q[k]) begin
                    db_cnt_q[k] <= '0;
                end else if (db_cnt_q[k] == DB_LAST) begin
                    db_q[k]     <= s2_q[k];
                    db_cnt_q[k] <= '0;
                end else begin
                    db_cnt_q[k] <= db_cnt_q[k] + DB_W'(1);
                end
            end
        end
    end

    // Rising edge of the debounced state: a held key yields a single step.
    assign press  = db_q & ~db_prev_q;
    assign period = BASE_P >> level_q;

    always_comb begin
        step_lvl        = level_q;
        level_d         = level_q;
        level_changed_d = 1'b0;
        restart         = 1'b0;
        cnt_d           = cnt_q;
        beat_d          = 1'b0;

        // Simultaneous up and down presses (2'b11) fall to default and cancel.
        case (press)
            2'b01: begin
                if (level_q == LVL_MAX) begin
                    step_lvl = (WRAP != 0) ? '0 : level_q;
                end else begin
                    step_lvl = level_q + LEVEL_W'(1);
                end
            end
            2'b10: begin
                if (level_q == '0) begin
                    step_lvl = (WRAP != 0) ? LVL_MAX : level_q;
                end else begin
                    step_lvl = level_q - LEVEL_W'(1);
                end
            end
            default: step_lvl = level_q;
        endcase
        level_d = step_lvl;

`ifdef TEMPO_SEL_EN
        sel_clamped = sel_level;
        if (int'(sel_level) > LEVELS - 1) begin
            sel_clamped = LVL_MAX;
        end
        // A direct select overrides any key step and always restarts the
        // beat count, even when it reloads the current level.
        if (sel_valid) begin
            level_d = sel_clamped;
            restart = 1'b1;
        end
`endif

        // Saturated presses leave the level alone and therefore do not pulse.
        level_changed_d = (level_d != level_q);
        if (level_changed_d) begin
            restart = 1'b1;
        end

        // Restart wins over the terminal count so the first beat after a
        // change lands exactly one new period later.
        if (restart) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == period - CNT_W'(1)) begin
                cnt_d  = '0;
                beat_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q         <= LVL_RESET;
            level_changed_q <= 1'b0;
            cnt_q           <= '0;
            beat_q          <= 1'b0;
        end else begin
            level_q         <= level_d;
            level_changed_q <= level_changed_d;
            cnt_q           <= cnt_d;
            beat_q          <= beat_d;
        end
    end

    assign level         = level_q;
    assign level_changed = level_changed_q;
    assign beat          = beat_q;

endmodule

// File: tb/tb_tempo_divider.sv
// tb/tb_tempo_divider.sv - scoreboard testbench for tempo_divider (wrapping and saturating instances)

module tb_tempo_divider;

    localparam int D    = 4;
    localparam int BASE = 16;
    localparam int L    = 4;

    typedef struct {
        int       e;
        int       lvl_w;
        int       lvl_s;
        bit [1:0] chg;
        bit [1:0] rst;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_up = 1'b0;
    logic        key_down = 1'b0;
    logic        enable = 1'b1;
`ifdef TEMPO_SEL_EN
    logic        sel_valid = 1'b0;
    logic [1:0]  sel_level = 2'd0;
`endif
    logic [1:0]  level_w, level_s;
    logic [27:0] period_w, period_s;
    logic        beat_w, beat_s;
    logic        lc_w, lc_s;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_n  = 0;
    int   m_w     = 0;
    int   m_s     = 0;
    exp_t expq[$];

    always #5 clk = ~clk;

    tempo_divider #(.LEVELS(L), .BASE_PERIOD(BASE), .DEBOUNCE_CYCLES(D), .WRAP(1)) u_wrap (
        .clk(clk), .reset(reset), .key_up(key_up), .key_down(key_down), .enable(enable),
`ifdef TEMPO_SEL_EN
        .sel_valid(sel_valid), .sel_level(sel_level),
`endif
        .level(level_w), .period(period_w), .beat(beat_w), .level_changed(lc_w)
    );

    tempo_divider #(.LEVELS(L), .BASE_PERIOD(BASE), .DEBOUNCE_CYCLES(D), .WRAP(0)) u_sat (
        .clk(clk), .reset(reset), .key_up(key_up), .key_down(key_down), .enable(enable),
`ifdef TEMPO_SEL_EN
        .sel_valid(sel_valid), .sel_level(sel_level),
`endif
        .level(level_s), .period(period_s), .beat(beat_s), .level_changed(lc_s)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    function automatic int step_wrap(input int lvl, input int dir);
        return (lvl + dir + L) % L;
    endfunction

    function automatic int step_sat(input int lvl, input int dir);
        int n;
        n = lvl + dir;
        if (n < 0) n = 0;
        if (n > L - 1) n = L - 1;
        return n;
    endfunction

    task automatic push_step(input int at, input int dir);
        exp_t x;
        x.e     = at;
        x.lvl_w = step_wrap(m_w, dir);
        x.lvl_s = step_sat(m_s, dir);
        x.chg   = {x.lvl_s != m_s, x.lvl_w != m_w};
        x.rst   = x.chg;
        m_w     = x.lvl_w;
        m_s     = x.lvl_s;
        expq.push_back(x);
    endtask

    // Monitor: owns the edge counter and the expected beat schedule.
    int   cur[2];
    int   nb[2];
    int   lv[2];
    int   pr[2];
    bit   bt[2];
    bit   lc[2];
    bit   ev;
    exp_t ex;

    always @(posedge clk) begin
        #1;
        edge_n++;
        lv[0] = int'(level_w);  lv[1] = int'(level_s);
        pr[0] = int'(period_w); pr[1] = int'(period_s);
        bt[0] = beat_w;         bt[1] = beat_s;
        lc[0] = lc_w;           lc[1] = lc_s;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("reset_level[%0d]", i), lv[i], 0);
                check($sformatf("reset_beat[%0d]", i), int'(bt[i]), 0);
                check($sformatf("reset_lc[%0d]", i), int'(lc[i]), 0);
                cur[i] = 0;
                nb[i]  = edge_n + BASE;
            end
            expq.delete();
        end else begin
            ev = 1'b0;
            if (expq.size() > 0 && expq[0].e == edge_n) begin
                ex = expq.pop_front();
                ev = 1'b1;
            end
            for (int i = 0; i < 2; i++) begin
                if (ev) cur[i] = (i == 0) ? ex.lvl_w : ex.lvl_s;
                check($sformatf("level_changed[%0d]", i), int'(lc[i]), int'(ev && ex.chg[i]));
                check($sformatf("level[%0d]", i), lv[i], cur[i]);
                check($sformatf("period[%0d]", i), pr[i], BASE >> cur[i]);
                if (ev && ex.rst[i]) nb[i] = edge_n + (BASE >> cur[i]);
                else if (!enable) nb[i]++;
                check($sformatf("beat[%0d]", i), int'(bt[i]), int'(edge_n == nb[i]));
                if (edge_n == nb[i]) nb[i] = edge_n + (BASE >> cur[i]);
            end
        end
    end

    task automatic do_reset(output int r);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_w = 0;
        m_s = 0;
        r = edge_n;
    endtask

    // Hold up for lu cycles and down for ld cycles from the same edge, then idle.
    task automatic keys(input int lu, input int ld, input int gap);
        int t0, mx;
        bit up, dn;
        @(negedge clk);
        t0 = edge_n + 1;
        mx = (lu > ld) ? lu : ld;
        up = (lu >= D);
        dn = (ld >= D);
        if (up != dn) push_step(t0 + D + 2, up ? 1 : -1);
        for (int n = 0; n < mx; n++) begin
            if (n > 0) @(negedge clk);
            key_up   = (n < lu);
            key_down = (n < ld);
        end
        @(negedge clk);
        key_up   = 1'b0;
        key_down = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic wait_beat(input string name, input int exp_edge);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 64 && !found; k++) begin
            @(negedge clk);
            if (beat_w) found = 1'b1;
        end
        if (!found) check({name, "_timeout"}, 0, 1);
        else check(name, edge_n, exp_edge);
    endtask

    initial begin
        int r, lu, ld;
        do_reset(r);
        wait_beat("first_beat_edge", r + BASE);
        wait_beat("second_beat_edge", r + 2 * BASE);

        keys(30, 0, D + 6);
        check("held_key_level", int'(level_w), 1);
        keys(3, 0, D + 6);
        check("glitch_level", int'(level_w), 1);

        do_reset(r);
        for (int k = 0; k < 4; k++) keys(D, 0, D + 5);
        check("wrap_after_four_ups", int'(level_w), 0);
        check("sat_after_four_ups", int'(level_s), 3);

        keys(6, 6, D + 6);
        check("both_keys_level", int'(level_w), 0);
        keys(0, 5, D + 6);
        check("down_wrap_level", int'(level_w), 3);

        do_reset(r);
        repeat (5) @(negedge clk);
        enable = 1'b0;
        repeat (10) @(negedge clk);
        enable = 1'b1;
        wait_beat("enable_resume_edge", r + 26);

        for (int k = 0; k < 30; k++) begin
            lu = $urandom_range(0, D + 4);
            ld = ($urandom_range(0, 2) == 0) ? $urandom_range(0, D + 4) : 0;
            if (lu == 0 && ld == 0) ld = D;
            keys(lu, ld, $urandom_range(D + 4, D + 10));
        end

`ifdef TEMPO_SEL_EN
        begin
            int t0;
            exp_t x;
            @(negedge clk);
            t0 = edge_n + 1;
            key_up = 1'b1;
            x.e = t0 + D + 2; x.lvl_w = 2; x.lvl_s = 2;
            x.chg = {m_s != 2, m_w != 2}; x.rst = 2'b11;
            m_w = 2; m_s = 2;
            expq.push_back(x);
            for (int n = 1; n <= D + 5; n++) begin
                @(negedge clk);
                sel_valid = (n == D + 2);
                sel_level = 2'd2;
            end
            @(negedge clk);
            key_up = 1'b0;
            sel_valid = 1'b0;
            repeat (D + 6) @(negedge clk);
            check("sel_level", int'(level_w), 2);
            check("sel_period", int'(period_w), 4);
            @(negedge clk);
            sel_valid = 1'b1;
            x.e = edge_n + 1; x.chg = 2'b00; x.rst = 2'b11;
            expq.push_back(x);
            @(negedge clk);
            sel_valid = 1'b0;
            repeat (8) @(negedge clk);
        end
`endif

        repeat (40) @(negedge clk);
        check("queue_drained", expq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tempo_divider.md
Name: tempo_divider

Overview:
- Parametrised tempo generator for the sequencer. It replaces the fixed four-step speed selector with a configurable one.
- Two debounced pushbuttons (up/down) step a tempo level through LEVELS settings. Wrap or saturate at the ends is selectable.
- The block derives a beat period from the level and produces a single-cycle beat strobe. Note-stepping logic consumes this strobe directly.

Parameters:
- CNT_W, 28, width of the period and beat counter.
- LEVELS, 4, number of tempo levels; must be >= 2 and <= 2**LEVEL_W.
- LEVEL_W, 2, width of the level register.
- BASE_PERIOD, 40000000, period in clk cycles at level 0 (slowest).
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a key change; must be >= 1.
- DB_W, 18, width of each debounce counter.
- WRAP, 1, 1 = wrap at the ends, 0 = saturate at the ends.
- RESET_LEVEL, 0, level loaded on reset.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- key_up  in  1  raw asynchronous pushbutton, active-high; request faster tempo.
- key_down  in  1  raw asynchronous pushbutton, active-high; request slower tempo.
- enable  in  1  beat counter runs when high.
- level  out  LEVEL_W  current tempo level.
- period  out  CNT_W  current beat period in cycles.
- beat  out  1  one-cycle strobe, once per period.
- level_changed  out  1  one-cycle strobe, coincident with a level update.

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is synchronous and active-high on port reset.
- Reset values:
  - level = RESET_LEVEL; beat = 0; level_changed = 0.
  - Beat counter = 0; sync flops = 0; debounced states = 0; debounce counters = 0.
- Input conditioning, per key:
  - 2-flop synchroniser, s1 then s2.
  - Debounce counter clears whenever s2 == db_state. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while s2 still differs, db_state <= s2 and the counter clears.
  - Press pulse = db_state & ~db_state_d (registered previous value).
  - A glitch shorter than DEBOUNCE_CYCLES cycles is discarded.
- Level update, registered; level and level_changed change together:
  - Latency: D+2 edges after the first edge that samples the raw key high, where D = DEBOUNCE_CYCLES.
  - Up press only: level+1. At LEVELS-1, go to 0 if WRAP=1, else hold.
  - Down press only: level-1. At 0, go to LEVELS-1 if WRAP=1, else hold.
  - Up and down press in the same cycle: both ignored; level unchanged, level_changed = 0.
  - A press that leaves the level unchanged (saturation) gives level_changed = 0.
  - Holding a key produces exactly one step. Release must be debounced before the next step.
- Period:
  - period = BASE_PERIOD >> level, combinational from level.
  - Level 0 = BASE_PERIOD, level 1 = BASE_PERIOD/2, and so on.
  - Integrator guarantees BASE_PERIOD >> (LEVELS-1) >= 2.
- Beat counter:
  - While enable = 1: if cnt == period-1, then cnt <= 0 and beat <= 1. Otherwise cnt <= cnt+1 and beat <= 0.
  - Steady-state beat spacing is exactly period cycles.
  - enable = 0: cnt holds, beat = 0. Re-enable resumes from the held count.
  - On a level_changed cycle, cnt <= 0 and beat <= 0. The first beat after a change arrives period(new) cycles later. This takes priority over the terminal-count check.
  - Reset mid-count: cnt = 0 and beat = 0 next edge; any in-flight debounce is discarded.

Optional Feature:
- Macro: TEMPO_SEL_EN.
- Defined: adds ports sel_valid (in, 1) and sel_level (in, LEVEL_W).
  - When sel_valid = 1: level <= sel_level, clamped to LEVELS-1 if larger; cnt <= 0.
  - level_changed pulses only if the value differs from the current level.
  - sel_valid has priority over key presses in the same cycle; those presses are dropped.
- Undefined: ports absent; level is key-controlled only.

Test Plan (bench params: DEBOUNCE_CYCLES=4, BASE_PERIOD=16, LEVELS=4, WRAP=1):
1. Reset, enable=1, no keys -> level=0, period=16; beat pulses every 16 cycles, first beat on the 16th edge after reset release.
2. key_up held high from edge 0 -> level=1 and level_changed=1 exactly at edge 6; period=8; next beat 8 cycles later; holding the key gives no further step.
3. key_up pulse of 3 cycles -> no level change. Four up presses from level 0 -> 1,2,3,0 with WRAP=1; with WRAP=0 -> 1,2,3,3, and level_changed absent on the last.
4. key_up and key_down debounced on the same cycle -> level unchanged, level_changed=0. Down from level 0 -> 3 with WRAP=1.
5. enable=0 at cnt=5 for 10 cycles -> no beat, cnt holds 5. Re-enable -> beat after 11 more cycles at period 16. Reset asserted mid-count -> beat=0, level=0, cnt=0.
6. TEMPO_SEL_EN defined: sel_valid=1, sel_level=2 with key_up pressed the same cycle -> level=2, period=4, key ignored. sel_level=2 again -> level_changed=0.
